fetch_unit: RTL and testbench
=============================

# fetch_unit

Multi-cycle instruction fetch stage with a registered PC, a request/response handshake to instruction memory, and a one-entry instruction holding register. It drives the 32-bit instruction word consumed by decode and the immediate generator. It also takes the sign-extended immediate back from the immediate generator to compute branch and jump targets. One instruction is in flight at a time, and the PC advances only when decode accepts the held instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_rsp_valid`  in  1  response data valid; single-cycle pulse, no back-pressure.
- `imem_rsp_data`  in  32  fetched instruction word.
- `instr`  out  32  held instruction, registered.
- `instr_valid`  out  1  `instr` is valid for decode.
- `instr_ready`  in  1  decode consumes `instr` this cycle.
- `pc`  out  32  PC of the current or held instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `imm_ext`  in  32  sign-extended immediate of the held instruction.
- `rs1_data`  in  32  register-file rs1 value, used for jalr.
- `branch_taken`  in  1  held instruction is a taken conditional branch.
- `jal`  in  1  held instruction is jal.
- `jalr`  in  1  held instruction is jalr.
- `misaligned`  out  1  sticky fault: target address not 4-byte aligned.

## Operation
- **States:** REQ, WAIT, HOLD, FAULT.
- **REQ:**
  - `imem_req_valid`=1.
  - If `imem_req_ready`=1, go to WAIT.
- **WAIT:**
  - `imem_req_valid`=0.
  - If `imem_rsp_valid`=1, capture `imem_rsp_data` into `instr`, set `instr_valid`=1, go to HOLD.
- **HOLD:**
  - `instr_valid`=1; `instr` and `pc` are stable.
  - If `instr_ready`=1, update `pc` with next_pc, clear `instr_valid`, go to REQ. Exception: if next_pc[1:0]≠0, go to FAULT instead.
- **next_pc priority:**
  - jalr: (`rs1_data` + `imm_ext`) & ~32'h1
  - else jal or branch_taken: `pc` + `imm_ext`
  - else: `pc` + 4
- **Sampling:** control inputs are sampled only in the HOLD cycle where `instr_ready`=1. They are ignored in all other states.
- **Arithmetic:** all adds are 32-bit with the carry discarded. For example, 0xFFFF_FFFC + 4 = 0x0000_0000.
- **FAULT:**
  - `misaligned`=1, `imem_req_valid`=0, `instr_valid`=0.
  - `pc` keeps the faulting instruction's PC.
  - Only `rst` exits FAULT.
- **Spurious responses:** `imem_rsp_valid` in REQ, HOLD or FAULT is ignored and `instr` is not modified.
- **Reset values:**
  - state=REQ, `pc`=`imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4
  - `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `misaligned`=0
  - `imem_req_valid`=0 while `rst`=1
- **Reset mid-operation:** `rst` wins over every transition. The in-flight fetch is abandoned, and a response arriving in the first REQ cycle after reset is dropped. Instruction memory shares `rst`.

## Timing
- **Reset release:** `rst` falls before edge 0. REQ is asserted in cycle 0.
- **Best case per instruction:**
  - req_ready in cycle 0 → WAIT in cycle 1.
  - rsp_valid in cycle 1 → `instr_valid` in cycle 2.
  - instr_ready in cycle 2 → REQ with the new `pc` in cycle 3.
  - Throughput is one instruction per 3 cycles.
- **Stalls:** each cycle without req_ready, rsp_valid or instr_ready adds exactly one cycle in the current state.
- **Stable outputs:** `instr`, `pc` and `pc_plus4` do not change between the capture edge and the acceptance edge.
- **Output paths:** no combinational path from any input to `imem_req_valid` or `instr_valid`. `imem_addr` is combinational from `pc` only.

## Structure
- **Package `fetch_pkg`:** state enum (REQ, WAIT, HOLD, FAULT), NOP constant 32'h0000_0013, default reset PC.
- **Sub-module `next_pc_calc`:** combinational. Takes `pc`, `imm_ext`, `rs1_data`, `branch_taken`, `jal` and `jalr`; produces next_pc and the misalign flag. Instantiated once in `fetch_unit`.

## Test plan
- **Sequential fetch:** `RESET_PC`=0, ready=1, 1-cycle response latency → addresses 0x0, 0x4, 0x8; `instr_valid` rises in cycles 2, 5, 8.
- **Back-pressure:** hold `instr_ready`=0 for 4 cycles in HOLD → `instr`/`pc` unchanged, no new request; request for 0x4 follows the accepting cycle.
- **Branch/jal priority:** pc=0x100 with `imm_ext`=0xFFFF_FFF0.
  - branch_taken → next address 0xF0.
  - jal+jalr with `rs1_data`=0x2001, `imm_ext`=0x10 → 0x2010 (jalr wins, bit 0 cleared).
- **Wrap and misalign:**
  - pc=0xFFFF_FFFC sequential → next 0x0.
  - jal with `imm_ext`=0x2 → FAULT, `misaligned`=1, no further requests.
  - `rst` clears the fault and restarts at `RESET_PC`.
- **Reset mid-WAIT:** assert `rst` in WAIT, then a response arrives in the first REQ cycle after reset → `instr` stays NOP, fetch restarts at `RESET_PC`.
- **Spurious response:** `imem_rsp_valid` pulse in HOLD → `instr` unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the held instruction plus its
// word-alignment check; jalr has priority over jal/branch.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_ext_i,
  input  logic [31:0] rs1_data_i,
  input  logic        branch_taken_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] seq_pc_s;
  logic [31:0] rel_pc_s;
  logic [31:0] reg_pc_s;

  assign seq_pc_s = pc_i + 32'd4;
  assign rel_pc_s = pc_i + imm_ext_i;
  assign reg_pc_s = (rs1_data_i + imm_ext_i) & ~32'h0000_0001;

  // Target priority: jalr, then jal/taken branch, then sequential.
  always_comb begin
    next_pc_o = seq_pc_s;
    if (jalr_i) begin
      next_pc_o = reg_pc_s;
    end else if (jal_i || branch_taken_i) begin
      next_pc_o = rel_pc_s;
    end else begin
      next_pc_o = seq_pc_s;
    end
  end

  assign misaligned_o = addr_misaligned(next_pc_o);

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch stage: one request in flight, a one-entry instruction
// holding register, and a PC that advances only when decode accepts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs1_data,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  output logic        misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         req_valid_q, req_valid_d;
  logic         misaligned_q, misaligned_d;

  logic [31:0]  next_pc_s;
  logic         next_misaligned_s;

  next_pc_calc u_next_pc_calc (
    .pc_i           (pc_q),
    .imm_ext_i      (imm_ext),
    .rs1_data_i     (rs1_data),
    .branch_taken_i (branch_taken),
    .jal_i          (jal),
    .jalr_i         (jalr),
    .next_pc_o      (next_pc_s),
    .misaligned_o   (next_misaligned_s)
  );

  // Next-state logic; flag outputs are derived from the next state so
  // that they leave the flops with no input-to-output combinational path.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    case (state_q)
      REQ: begin
        // req_valid_q gates the handshake so the post-reset cycle cannot accept.
        if (req_valid_q && imem_req_ready) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          if (next_misaligned_s) begin
            state_d = FAULT;
          end else begin
            pc_d       = next_pc_s;
            pc_plus4_d = next_pc_s + 32'd4;
            state_d    = REQ;
          end
        end else begin
          state_d = HOLD;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = REQ;
      end
    endcase
    req_valid_d   = (state_d == REQ);
    instr_valid_d = (state_d == HOLD);
    misaligned_d  = (state_d == FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      req_valid_q   <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      req_valid_q   <= req_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: requests push expected {pc, word},
// captured instructions pop and compare.
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] imm_ext;
  logic [31:0] rs1_data;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic        misaligned;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .imm_ext        (imm_ext),
    .rs1_data       (rs1_data),
    .branch_taken   (branch_taken),
    .jal            (jal),
    .jalr           (jalr),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle following the first edge that samples rst low.
  always @(posedge clk) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic br,
                                             input logic jl, input logic jr,
                                             input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    if (jr)             t = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jl || br)  t = p + imm;
    else                t = p + 32'd4;
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    imm_ext        = 32'h0;
    rs1_data       = 32'h0;
    branch_taken   = 1'b0;
    jal            = 1'b0;
    jalr           = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    exp_pc_q.delete();
    exp_instr_q.delete();
    rst = 1'b0;
  endtask

  // One complete fetch with configurable stalls; returns the cycle instr_valid rose.
  task automatic do_fetch(input logic [31:0] exp_pc, input int ready_dly, input int rsp_dly,
                          input int acc_dly, input logic spur, input logic br, input logic jl,
                          input logic jr, input logic [31:0] imm, input logic [31:0] rs1,
                          output int valid_cyc);
    int n;
    logic [31:0] epc, einstr, nxt;
    n = 0;
    valid_cyc = -1;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL req_wait: imem_req_valid=%b expected 1", imem_req_valid);
    end
    checks++;
    if (imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL req_addr: imem_addr=%h expected %h", imem_addr, exp_pc);
    end
    for (int i = 0; i < ready_dly; i++) begin
      if (spur && i == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
      end
      tick();
      imem_rsp_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL req_stall: req_valid=%b addr=%h expected 1 %h", imem_req_valid, imem_addr, exp_pc);
      end
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    exp_pc_q.push_back(exp_pc);
    exp_instr_q.push_back(mem_word(exp_pc));
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
    end
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_stall: instr_valid=%b req_valid=%b expected 0 0", instr_valid, imem_req_valid);
      end
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(exp_pc);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    valid_cyc = cyc;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid: instr_valid=%b expected 1", instr_valid);
    end
    if (exp_pc_q.size() > 0) begin
      epc    = exp_pc_q.pop_front();
      einstr = exp_instr_q.pop_front();
      checks++;
      if (instr !== einstr || pc !== epc || pc_plus4 !== epc + 32'd4) begin
        errors++;
        $display("FAIL hold_data: instr=%h pc=%h pc_plus4=%h expected %h %h %h",
                 instr, pc, pc_plus4, einstr, epc, epc + 32'd4);
      end
    end else begin
      epc = exp_pc;
      einstr = mem_word(exp_pc);
    end
    for (int i = 0; i < acc_dly; i++) begin
      branch_taken = 1'($urandom);
      jal          = 1'($urandom);
      jalr         = 1'($urandom);
      imm_ext      = $urandom;
      rs1_data     = $urandom;
      if (spur && i == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0002;
      end
      tick();
      imem_rsp_valid = 1'b0;
      checks++;
      if (instr !== einstr || pc !== epc || instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: instr=%h pc=%h iv=%b rv=%b expected %h %h 1 0",
                 instr, pc, instr_valid, imem_req_valid, einstr, epc);
      end
    end
    branch_taken = br;
    jal          = jl;
    jalr         = jr;
    imm_ext      = imm;
    rs1_data     = rs1;
    instr_ready  = 1'b1;
    tick();
    clear_inputs();
    nxt = model_next(exp_pc, br, jl, jr, imm, rs1);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_clear: instr_valid=%b expected 0", instr_valid);
    end
    checks++;
    if (nxt[1:0] != 2'b00) begin
      if (misaligned !== 1'b1 || imem_req_valid !== 1'b0 || pc !== exp_pc) begin
        errors++;
        $display("FAIL fault_entry: misaligned=%b req_valid=%b pc=%h expected 1 0 %h",
                 misaligned, imem_req_valid, pc, exp_pc);
      end
    end else begin
      if (imem_req_valid !== 1'b1 || pc !== nxt || imem_addr !== nxt ||
          pc_plus4 !== nxt + 32'd4 || misaligned !== 1'b0) begin
        errors++;
        $display("FAIL next_pc: rv=%b pc=%h addr=%h p4=%h mis=%b expected 1 %h %h %h 0",
                 imem_req_valid, pc, imem_addr, pc_plus4, misaligned, nxt, nxt, nxt + 32'd4);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: rv=%b iv=%b mis=%b expected 0 0 0", imem_req_valid, instr_valid, misaligned);
    end
    checks++;
    if (pc !== TB_RESET_PC || imem_addr !== TB_RESET_PC || pc_plus4 !== TB_RESET_PC + 32'd4) begin
      errors++;
      $display("FAIL reset_pc: pc=%h addr=%h p4=%h expected %h %h %h", pc, imem_addr, pc_plus4,
               TB_RESET_PC, TB_RESET_PC, TB_RESET_PC + 32'd4);
    end
    checks++;
    if (instr !== TB_NOP) begin
      errors++;
      $display("FAIL reset_instr: instr=%h expected %h", instr, TB_NOP);
    end
    clear_inputs();
  endtask

  task automatic test_sequential;
    int c0, c1, c2;
    do_reset();
    do_fetch(32'h0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c0);
    do_fetch(32'h4, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c1);
    do_fetch(32'h8, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c2);
    checks++;
    if (c0 != 2 || c1 != 5 || c2 != 8) begin
      errors++;
      $display("FAIL seq_timing: valid cycles %0d %0d %0d expected 2 5 8", c0, c1, c2);
    end
  endtask

  task automatic test_back_pressure;
    int c;
    do_reset();
    do_fetch(32'h0, 2, 3, 4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
    do_fetch(32'h4, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
  endtask

  task automatic test_branch_priority;
    int c;
    do_reset();
    do_fetch(32'h0,   0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, c);
    do_fetch(32'h100, 0, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, c);
    do_fetch(32'hF0,  1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_2001, c);
    do_fetch(32'h2010, 0, 2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, c);
    do_fetch(32'h2030, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
  endtask

  task automatic test_wrap_misalign;
    int c;
    do_reset();
    do_fetch(32'h0,         0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC, c);
    do_fetch(32'hFFFF_FFFC, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
    do_fetch(32'h0,         0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
    do_fetch(32'h4,         0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'h0, c);
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0003;
      tick();
      checks++;
      if (misaligned !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h4) begin
        errors++;
        $display("FAIL fault_sticky: mis=%b rv=%b iv=%b pc=%h expected 1 0 0 00000004",
                 misaligned, imem_req_valid, instr_valid, pc);
      end
    end
    clear_inputs();
    do_reset();
    checks++;
    if (misaligned !== 1'b0 || pc !== TB_RESET_PC) begin
      errors++;
      $display("FAIL fault_reset: mis=%b pc=%h expected 0 %h", misaligned, pc, TB_RESET_PC);
    end
    do_fetch(TB_RESET_PC, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0005, c);
  endtask

  task automatic test_reset_mid_wait;
    int c;
    do_reset();
    do_fetch(32'h0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_state: req_valid=%b expected 0", imem_req_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== TB_RESET_PC) begin
      errors++;
      $display("FAIL mid_wait_restart: rv=%b addr=%h expected 1 %h", imem_req_valid, imem_addr, TB_RESET_PC);
    end
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    checks++;
    if (instr !== TB_NOP || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_drop: instr=%h iv=%b expected %h 0", instr, instr_valid, TB_NOP);
    end
    do_fetch(TB_RESET_PC, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
  endtask

  task automatic test_spurious;
    int c;
    do_reset();
    do_fetch(32'h0, 2, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
    do_fetch(32'h4, 1, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0, c);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_back_pressure();
    test_branch_priority();
    test_wrap_misalign();
    test_reset_mid_wait();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
